// File: rtl/elevator_ctrl.sv
// elevator_ctrl: 4-floor car controller with SCAN scheduling and timed door dwell.
// Optional DOOR_HOLD_EN adds a door_hold input that keeps the door open while it is high.
module elevator_ctrl #(
  parameter int TRAVEL_CYCLES = 50_000_000,
  parameter int DOOR_CYCLES   = 100_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
`ifdef DOOR_HOLD_EN
  input  logic       door_hold,
`endif
  output logic [1:0] floor,
  output logic       moving_up,
  output logic       moving_down,
  output logic       door_open,
  output logic [3:0] pending
);
  localparam int MAXC = TRAVEL_CYCLES > DOOR_CYCLES ? TRAVEL_CYCLES : DOOR_CYCLES;
  localparam int TW = MAXC > 1 ? $clog2(MAXC) : 1;
  localparam logic [TW-1:0] TRAVEL_LD = TW'(TRAVEL_CYCLES - 1);
  localparam logic [TW-1:0] DOOR_LD = TW'(DOOR_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, MOVE, DOOR} state_t;
  state_t state, state_n;
  logic dir, dir_n, hold;
  logic [1:0] floor_n, nf;
  logic [TW-1:0] timer, timer_n;
  logic [3:0] pending_n, clr;
`ifdef DOOR_HOLD_EN
  assign hold = door_hold;
`else
  assign hold = 1'b0;
`endif
  function automatic logic above_of(input logic [1:0] f, input logic [3:0] p);
    return |(p & (4'b1110 << f));
  endfunction
  function automatic logic below_of(input logic [1:0] f, input logic [3:0] p);
    return |(p & ~(4'b1111 << f));
  endfunction
  assign nf = dir ? floor + 2'd1 : floor - 2'd1;
  always_comb begin
    state_n = state;
    dir_n = dir;
    floor_n = floor;
    timer_n = timer;
    case (state)
      IDLE: begin
        if (pending[floor]) begin
          state_n = DOOR;
          timer_n = DOOR_LD;
        end else if (above_of(floor, pending) && (dir || !below_of(floor, pending))) begin
          state_n = MOVE;
          dir_n = 1'b1;
          timer_n = TRAVEL_LD;
        end else if (below_of(floor, pending)) begin
          state_n = MOVE;
          dir_n = 1'b0;
          timer_n = TRAVEL_LD;
        end
      end
      MOVE: begin
        if (timer != '0) begin
          timer_n = timer - 1'b1;
        end else begin
          floor_n = nf;
          if (pending[nf]) begin
            state_n = DOOR;
            timer_n = DOOR_LD;
          end else if (dir ? above_of(nf, pending) : below_of(nf, pending)) begin
            timer_n = TRAVEL_LD;
          end else begin
            state_n = IDLE;
          end
        end
      end
      DOOR: begin
        if (hold) timer_n = DOOR_LD;
        else if (timer != '0) timer_n = timer - 1'b1;
        else state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    // calls for the floor the door is open at are served immediately, never latched
    clr = (state_n == DOOR || state == DOOR) ? 4'b0001 << floor_n : 4'b0000;
    pending_n = (pending | req) & ~clr;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      dir <= 1'b1;
      floor <= 2'd0;
      timer <= '0;
      pending <= 4'b0000;
    end else begin
      state <= state_n;
      dir <= dir_n;
      floor <= floor_n;
      timer <= timer_n;
      pending <= pending_n;
    end
  end
  assign moving_up = (state == MOVE) && dir;
  assign moving_down = (state == MOVE) && !dir;
  assign door_open = state == DOOR;
endmodule

// File: tb/tb_elevator_ctrl.sv
// tb_elevator_ctrl: scoreboard bench; expected stop floors are queued as calls are made
// and checked as each door opens, alongside directed cycle-exact checks.
module tb_elevator_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] req = 4'b0000;
`ifdef DOOR_HOLD_EN
  logic door_hold = 1'b0;
`endif
  logic [1:0] floor;
  logic moving_up, moving_down, door_open;
  logic [3:0] pending;
  int n_tests = 0;
  int n_fail = 0;
  int sb[$];
  bit mon_en = 1'b0;
  int exp_dwell = 3;
  elevator_ctrl #(.TRAVEL_CYCLES(4), .DOOR_CYCLES(3)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req(req),
`ifdef DOOR_HOLD_EN
    .door_hold(door_hold),
`endif
    .floor(floor),
    .moving_up(moving_up),
    .moving_down(moving_down),
    .door_open(door_open),
    .pending(pending)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic pulse(input logic [3:0] r);
    req = r;
    @(negedge clk);
    req = 4'b0000;
  endtask
  task automatic wait_done(input int budget);
    int k = 0;
    while ((sb.size() != 0 || door_open || moving_up || moving_down) && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("settle", int'(k < budget), 1);
  endtask
  // stop order, door dwell and per-floor travel time are watched continuously
  initial begin
    logic pd;
    logic [1:0] pf;
    int dc, mc;
    pd = 1'b0;
    pf = 2'd0;
    dc = 0;
    mc = 0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (door_open && !pd) check("stop", int'(floor), sb.size() != 0 ? sb.pop_front() : -1);
        if (door_open) dc++;
        else if (pd) begin
          check("dwell", dc, exp_dwell);
          dc = 0;
        end
        if (floor != pf) begin
          check("step", mc, 4);
          mc = 0;
        end
        if (moving_up || moving_down) mc++;
      end else begin
        dc = 0;
        mc = 0;
      end
      pd = door_open;
      pf = floor;
    end
  end
  initial begin
    cyc(3);
    rst_n = 1'b1;
    cyc(10);
    check("rst_floor", int'(floor), 0);
    check("rst_pending", int'(pending), 0);
    check("rst_up", int'(moving_up), 0);
    check("rst_down", int'(moving_down), 0);
    check("rst_door", int'(door_open), 0);
    mon_en = 1'b1;
    sb.push_back(0);
    pulse(4'b0001);
    check("self_latch", int'(pending), 1);
    cyc(1);
    check("self_door", int'(door_open), 1);
    check("self_clr", int'(pending), 0);
    check("self_floor", int'(floor), 0);
    cyc(3);
    check("self_close", int'(door_open), 0);
    check("self_nomove", int'(moving_up | moving_down), 0);
    sb.push_back(2);
    pulse(4'b0100);
    check("a_latch", int'(pending), 4);
    cyc(1);
    check("a_up", int'(moving_up), 1);
    check("a_down", int'(moving_down), 0);
    check("a_start", int'(floor), 0);
    cyc(4);
    check("a_f1", int'(floor), 1);
    cyc(4);
    check("a_f2", int'(floor), 2);
    check("a_door", int'(door_open), 1);
    check("a_clr", int'(pending), 0);
    cyc(3);
    check("a_close", int'(door_open), 0);
    sb.push_back(3);
    sb.push_back(0);
    pulse(4'b1001);
    check("b_latch", int'(pending), 9);
    wait_done(200);
    check("b_floor", int'(floor), 0);
    check("b_pending", int'(pending), 0);
    sb.push_back(3);
    pulse(4'b1000);
    cyc(1);
    check("c_up", int'(moving_up), 1);
    sb.push_front(1);
    pulse(4'b0010);
    check("c_latch", int'(pending), 10);
    wait_done(200);
    check("c_floor", int'(floor), 3);
    check("c_pending", int'(pending), 0);
    sb.push_back(0);
    pulse(4'b0001);
    wait_done(200);
    check("d_home", int'(floor), 0);
    mon_en = 1'b0;
    pulse(4'b1000);
    cyc(6);
    check("d_mid_floor", int'(floor), 1);
    check("d_mid_up", int'(moving_up), 1);
    rst_n = 1'b0;
    cyc(1);
    check("d_rst_floor", int'(floor), 0);
    check("d_rst_pending", int'(pending), 0);
    check("d_rst_up", int'(moving_up), 0);
    check("d_rst_door", int'(door_open), 0);
    rst_n = 1'b1;
    cyc(5);
    check("d_after_floor", int'(floor), 0);
    check("d_after_move", int'(moving_up | moving_down), 0);
    mon_en = 1'b1;
`ifdef DOOR_HOLD_EN
    exp_dwell = 13;
    sb.push_back(0);
    pulse(4'b0001);
    cyc(1);
    check("h_door", int'(door_open), 1);
    door_hold = 1'b1;
    cyc(10);
    door_hold = 1'b0;
    cyc(2);
    check("h_still_open", int'(door_open), 1);
    cyc(1);
    check("h_closed", int'(door_open), 0);
    cyc(1);
    exp_dwell = 3;
`endif
    cyc(2);
    check("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
